// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: groups the user-facing signals of the LED pattern
// controller. The controller is the slave: it consumes the raw button and
// drives the LED and the current mode. The driver of the button (board glue
// or a testbench) uses the master modport.
interface led_pattern_ctrl_if;
   logic       btn;   // raw, asynchronous, bouncing button; 1 = pressed
   logic       led;   // registered LED drive; 1 = lit
   logic [1:0] mode;  // 0 OFF, 1 SLOW, 2 FAST, 3 BREATHE

   modport master (
      output btn,
      input  led,
      input  mode
   );

   modport slave (
      input  btn,
      output led,
      output mode
   );
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: button-driven LED pattern generator.
//   btn is synchronized, debounced and its rising edge steps the mode
//   OFF -> SLOW -> FAST [-> BREATHE] -> OFF. A prescaler produces pattern
//   ticks; SLOW toggles the LED every 8 ticks, FAST every 2 ticks and
//   BREATHE drives a PWM whose duty ramps up and down one step per tick.
//   Every mode change restarts the pattern from a clean state.
// Optional feature: define LED_PATTERN_BREATHE_EN to build the BREATHE mode
// and its duty/PWM logic. Without it the mode sequence is 0 -> 1 -> 2 -> 0.
module led_pattern_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,  // stable samples to accept a level change (>= 2)
   parameter int TICK_CYCLES     = 1250000  // clk cycles per pattern tick (>= 2)
) (
   input  logic                clk,
   input  logic                rst,
   led_pattern_ctrl_if.slave   bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_SLOW    = 2'd1;
   localparam logic [1:0] MODE_FAST    = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   // Synchronizer and debouncer state
   logic            sync1_q;
   logic            sync2_q;
   logic            deb_q;
   logic            deb_d;
   logic            deb_prev_q;
   logic [DB_W-1:0] db_cnt_q;
   logic [DB_W-1:0] db_cnt_d;
   logic            press;

   // Mode FSM
   logic [1:0]      mode_q;
   logic [1:0]      mode_d;
   logic            mode_chg;
   logic            is_off;
   logic            is_slow;
   logic            is_fast;

   // Tick prescaler and pattern state
   logic [TK_W-1:0] presc_q;
   logic [TK_W-1:0] presc_d;
   logic            tick;
   logic [2:0]      phase_q;
   logic [2:0]      phase_d;
   logic            led_q;
   logic            led_d;

`ifdef LED_PATTERN_BREATHE_EN
   logic            is_breathe;
   logic [7:0]      duty_q;
   logic [7:0]      duty_d;
   logic            dir_up_q;
   logic            dir_up_d;
   logic [7:0]      pwm_q;
   logic [7:0]      pwm_d;
`endif

   // Two-flop synchronizer: the raw button is asynchronous to clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.btn;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive samples that disagree with the accepted level
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == deb_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         deb_d    = ~deb_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Debounced level, its one-cycle-old copy and the disagreement counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         db_cnt_q   <= '0;
      end else begin
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         db_cnt_q   <= db_cnt_d;
      end
   end

   // A press is the debounced 0->1 edge; release edges are ignored
   assign press    = deb_q & ~deb_prev_q;
   assign mode_chg = press;

   // Mode FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_OFF;
      end else begin
         mode_q <= mode_d;
      end
   end

   // Mode FSM next state: step through the available modes on each press
   always_comb begin
      mode_d = mode_q;
      if (press) begin
`ifdef LED_PATTERN_BREATHE_EN
         mode_d = mode_q + 2'd1;
`else
         mode_d = (mode_q == MODE_FAST) ? MODE_OFF : mode_q + 2'd1;
`endif
      end
   end

   // Mode FSM output decode used by the pattern generators
   always_comb begin
      is_off  = (mode_q == MODE_OFF);
      is_slow = (mode_q == MODE_SLOW);
      is_fast = (mode_q == MODE_FAST);
`ifdef LED_PATTERN_BREATHE_EN
      is_breathe = (mode_q == MODE_BREATHE);
`endif
   end

   // Prescaler: tick on the cycle it wraps; a mode change restarts it
   assign tick = (presc_q == TK_LAST);

   always_comb begin
      if (mode_chg || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // Pattern next state; a mode change clears everything and overrides a tick
   always_comb begin
      phase_d = phase_q;
      led_d   = led_q;
`ifdef LED_PATTERN_BREATHE_EN
      duty_d   = duty_q;
      dir_up_d = dir_up_q;
      pwm_d    = pwm_q + 8'd1;
`endif
      if (mode_chg) begin
         phase_d = 3'd0;
         led_d   = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
         duty_d   = 8'd0;
         dir_up_d = 1'b1;
`endif
      end else if (is_off) begin
         led_d = 1'b0;
      end else if (is_slow) begin
         if (tick) begin
            phase_d = phase_q + 3'd1;
            if (phase_q == 3'd7) begin
               led_d = ~led_q;
            end
         end
      end else if (is_fast) begin
         if (tick) begin
            phase_d = phase_q + 3'd1;
            if (phase_q[0]) begin
               led_d = ~led_q;
            end
         end
`ifdef LED_PATTERN_BREATHE_EN
      end else if (is_breathe) begin
         led_d = (pwm_q < duty_q);
         if (tick) begin
            // Reverse on reaching a limit so the limit value is not repeated
            if (dir_up_q) begin
               duty_d = duty_q + 8'd1;
               if (duty_q == 8'd254) begin
                  dir_up_d = 1'b0;
               end
            end else begin
               duty_d = duty_q - 8'd1;
               if (duty_q == 8'd1) begin
                  dir_up_d = 1'b1;
               end
            end
         end
`endif
      end else begin
         led_d = 1'b0;
      end
   end

   // Prescaler, phase and LED registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         phase_q <= 3'd0;
         led_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

`ifdef LED_PATTERN_BREATHE_EN
   // Breathe duty, ramp direction and free-running PWM counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q   <= 8'd0;
         dir_up_q <= 1'b1;
         pwm_q    <= 8'd0;
      end else begin
         duty_q   <= duty_d;
         dir_up_q <= dir_up_d;
         pwm_q    <= pwm_d;
      end
   end
`endif

   assign bus.led  = led_q;
   assign bus.mode = mode_q;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples needed to accept a button level change (>=2).
REQ-002 SHALL have parameter TICK_CYCLES, default 1250000: clk cycles per pattern tick (>=2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn  input  1  raw, asynchronous, bouncing mode-select button; 1 = pressed.
REQ-006 led  output 1  drive to the downstream blink_led/LED pin stage; 1 = lit.
REQ-007 mode output 2  current pattern mode: 0 OFF, 1 SLOW, 2 FAST, 3 BREATHE.

Function
REQ-008 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Debouncer: counter clears whenever synchronized btn equals debounced level; on reaching DEBOUNCE_CYCLES consecutive differing samples, debounced level flips and counter clears.
REQ-010 Shorter glitches (< DEBOUNCE_CYCLES differing samples) SHALL produce no debounced change.
REQ-011 Debounced 0->1 edge SHALL advance mode on the next clk edge: 0->1->2->3->0; the 1->0 edge SHALL have no effect.
REQ-012 Latency: mode updates exactly DEBOUNCE_CYCLES+3 clk edges after btn first samples high and stays stable.
REQ-013 Prescaler counts 0..TICK_CYCLES-1 and emits a one-cycle tick when wrapping to 0.
REQ-014 OFF: led = 0 constantly.
REQ-015 SLOW: 3-bit phase counter increments per tick; led toggles on each tick where the counter wraps 7->0 (period 16 ticks).
REQ-016 FAST: led toggles on every second tick (period 4 ticks).
REQ-017 BREATHE: 8-bit duty moves by 1 per tick, rising to 255 then falling to 0 then rising (direction reverses on reaching each limit, no repeat of limit value); free-running 8-bit PWM counter per clk; led = (pwm_cnt < duty).
REQ-018 On the clk edge that changes mode, prescaler, phase counter, duty (0), direction (up) and led (0) SHALL all clear; pattern restarts from that edge.
REQ-019 A button press arriving while ticks run SHALL be handled identically regardless of tick alignment; simultaneous tick and mode change: mode change wins.
REQ-020 led and mode SHALL be registered outputs (no combinational path from btn).

Reset
REQ-021 While rst = 1: sync flops 0, debounced level 0, debounce counter 0, prescaler 0, phase 0, duty 0, direction up, pwm_cnt 0, mode 0, led 0.
REQ-022 rst assertion mid-press or mid-pattern SHALL take effect immediately without clk; after deassertion a still-held btn SHALL be debounced afresh and then count as one press.

Configuration
REQ-023 Macro LED_PATTERN_BREATHE_EN: when defined, BREATHE mode and PWM logic present as above.
REQ-024 When undefined: no duty/PWM logic; mode sequence 0->1->2->0; mode never equals 3; all else unchanged.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=3, LED_PATTERN_BREATHE_EN defined unless stated)
REQ-025 Reset then hold btn=1 -> mode 0->1 exactly 7 clk edges after first sample of btn=1; led=0 until first toggle.
REQ-026 btn pulses high for 3 clk, low, repeated 5x -> mode stays 0, led stays 0.
REQ-027 Mode 2 -> led toggles every 6 clk (period 12); mode 1 -> period 48 clk, first toggle 24 clk after mode change.
REQ-028 Four clean presses -> mode 1,2,3,0; in mode 3 after 10 ticks duty=10, led high 10 of every 256 clk; duty sequence ...254,255,254... at top.
REQ-029 Assert rst for 1 clk during FAST with btn held -> led=0, mode=0 asynchronously; after release mode goes to 1 after 7 edges once.
REQ-030 Macro undefined, three presses -> mode 1,2,0; mode never 3.
